// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the select of a shared N:1 bit mux.
// A hold limit forces a handover so no requester can monopolise the output.
module rr_mux_arbiter #(
  parameter int N        = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         X,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] sel,
  output logic                 Y
);

  localparam int SEL_W  = $clog2(N);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]        r_state;
  logic [N-1:0]      r_gnt;
  logic              r_gnt_valid;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  r_ptr;
  logic [HOLD_W-1:0] r_hold;

  logic [SEL_W-1:0]  w_next_owner;
  logic [SEL_W-1:0]  w_start;
  logic [SEL_W-1:0]  w_cand;
  logic [SEL_W-1:0]  w_nidx;
  logic              w_nfound;
  logic              w_keep;

  assign w_next_owner = SEL_W'((int'(r_sel) + 1) % N);
  assign w_start      = (r_state == ST_IDLE) ? r_ptr : w_next_owner;
  assign w_keep       = req[r_sel] && (r_hold < HOLD_W'(MAX_HOLD));

  // While granting, the current owner is excluded so a handover never picks it back.
  always_comb begin
    w_nfound = 1'b0;
    w_nidx   = '0;
    w_cand   = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = SEL_W'((int'(w_start) + k) % N);
      if (!w_nfound && req[w_cand] &&
          !((r_state == ST_GRANT) && (w_cand == r_sel))) begin
        w_nfound = 1'b1;
        w_nidx   = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_sel       <= '0;
      r_ptr       <= '0;
      r_hold      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_nfound) begin
            r_state     <= ST_GRANT;
            r_gnt       <= {{(N-1){1'b0}}, 1'b1} << w_nidx;
            r_gnt_valid <= 1'b1;
            r_sel       <= w_nidx;
            r_hold      <= HOLD_W'(1);
          end
        end
        default: begin
          if (w_keep) begin
            r_hold <= r_hold + 1'b1;
          end else begin
            r_ptr <= w_next_owner;
            if (w_nfound) begin
              r_gnt  <= {{(N-1){1'b0}}, 1'b1} << w_nidx;
              r_sel  <= w_nidx;
              r_hold <= HOLD_W'(1);
            end else if (req[r_sel]) begin
              r_hold <= HOLD_W'(1);
            end else begin
              // sel is left at the last owner; Y is gated by gnt_valid.
              r_state     <= ST_IDLE;
              r_gnt       <= '0;
              r_gnt_valid <= 1'b0;
              r_hold      <= '0;
            end
          end
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign sel       = r_sel;
  assign Y         = r_gnt_valid & X[r_sel];

endmodule
